// File: rtl/phase_sequencer_pkg.sv
// Shared types and default sizing for the instruction phase sequencer.
package simple_pkg;

  localparam int DEF_NUM_PHASES = 5;
  localparam int DEF_MEM_PHASE  = 3;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } seq_state_t;

  function automatic int phase_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the front panel / datapath and the phase sequencer.
interface phase_sequencer_if
  import simple_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int CNT_W      = DEF_CNT_W
);
  localparam int PHASE_W = phase_width(NUM_PHASES);

  logic                  exec;
  logic                  step;
  logic                  halt_req;
  logic                  mem_ready;
  logic [PHASE_W-1:0]    phase;
  logic [NUM_PHASES-1:0] phase_onehot;
  logic                  running;
  logic                  halted;
  logic                  instr_done;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      instr_count;

  modport master (
    output exec, step, halt_req, mem_ready,
    input  phase, phase_onehot, running, halted, instr_done, cycle_count, instr_count
  );

  modport slave (
    input  exec, step, halt_req, mem_ready,
    output phase, phase_onehot, running, halted, instr_done, cycle_count, instr_count
  );

endinterface

// File: rtl/phase_sequencer_edge_detect.sv
// Rising-edge detector for level inputs; history resets high so a level held through reset is not a rise.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = level;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer with run/pause, memory stall and halt.
// Optional single-instruction stepping is enabled by defining SINGLE_STEP_EN.
//   state   | meaning
//   S_IDLE  | paused, waiting for exec (or step) rise
//   S_RUN   | phase advances every cycle
//   S_STALL | held at MEM_PHASE waiting for mem_ready
//   S_HALT  | halted by halt_req at wrap; only reset leaves
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int MEM_PHASE  = DEF_MEM_PHASE,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic             clock,
  input logic             reset,
  phase_sequencer_if.slave bus
);
  localparam int PHASE_W = phase_width(NUM_PHASES);
  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] MEM_PH  = PHASE_W'(MEM_PHASE);

  seq_state_t            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic                  pause_q, pause_d;
  logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]      instr_count_q, instr_count_d;
  logic                  exec_rise, step_rise;
  logic                  pause_now, stop_at_wrap, advance, at_last, instr_done;
  logic [NUM_PHASES-1:0] onehot;

  edge_detect u_exec_edge (.clock(clock), .reset(reset), .level(bus.exec), .rise(exec_rise));
  edge_detect u_step_edge (.clock(clock), .reset(reset), .level(bus.step), .rise(step_rise));

`ifdef SINGLE_STEP_EN
  logic step_mode_q, step_mode_d;

  always_ff @(posedge clock) begin
    if (reset) step_mode_q <= 1'b0;
    else       step_mode_q <= step_mode_d;
  end
`else
  logic step_unused;
  assign step_unused = step_rise;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      pause_q       <= 1'b0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      pause_q       <= pause_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    pause_d       = pause_q;
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    instr_done    = 1'b0;
    // A second exec rise while a pause is pending cancels it, hence the toggle.
    pause_now     = pause_q ^ exec_rise;
    at_last       = (phase_q == LAST_PH);
    advance       = (phase_q != MEM_PH) || bus.mem_ready;
`ifdef SINGLE_STEP_EN
    step_mode_d   = step_mode_q;
    stop_at_wrap  = pause_now | step_mode_q;
`else
    stop_at_wrap  = pause_now;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (exec_rise) state_d = S_RUN;
`ifdef SINGLE_STEP_EN
        else if (step_rise) begin
          state_d     = S_RUN;
          step_mode_d = 1'b1;
        end
`endif
      end
      S_RUN, S_STALL: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        pause_d       = pause_now;
        if (!advance) begin
          state_d = S_STALL;
        end else if (at_last) begin
          phase_d       = '0;
          instr_done    = 1'b1;
          instr_count_d = instr_count_q + CNT_W'(1);
          pause_d       = 1'b0;
`ifdef SINGLE_STEP_EN
          step_mode_d   = 1'b0;
`endif
          if (bus.halt_req)      state_d = S_HALT;
          else if (stop_at_wrap) state_d = S_IDLE;
          else                   state_d = S_RUN;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
          state_d = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_PHASES; i++) onehot[i] = (phase_q == PHASE_W'(i));
  end

  assign bus.phase        = phase_q;
  assign bus.phase_onehot = onehot;
  assign bus.running      = (state_q == S_RUN) || (state_q == S_STALL);
  assign bus.halted       = (state_q == S_HALT);
  assign bus.instr_done   = instr_done;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.instr_count  = instr_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed table-driven bench for phase_sequencer (default 5-phase build plus a 3-phase, 4-bit counter build).
module tb_phase_sequencer;
  import simple_pkg::*;

  typedef struct {
    bit exec;
    bit mr;
    bit halt;
    bit step;
    int ph;
    bit run;
    bit hlt;
    bit done;
    int ic;
    int cc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(16)) bus ();
  phase_sequencer_if #(.NUM_PHASES(3), .CNT_W(4))  bus2 ();

  phase_sequencer #(.NUM_PHASES(5), .MEM_PHASE(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  phase_sequencer #(.NUM_PHASES(3), .MEM_PHASE(1), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  function automatic vec_t mk(input bit e, m, h, s, input int ph, input bit r, hl, d,
                              input int ic, cc);
    vec_t v;
    v.exec = e; v.mr = m; v.halt = h; v.step = s;
    v.ph = ph; v.run = r; v.hlt = hl; v.done = d; v.ic = ic; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    bus.exec = v.exec; bus.mem_ready = v.mr; bus.halt_req = v.halt; bus.step = v.step;
    #1;
    chk({tag, " phase"},   int'(bus.phase), v.ph);
    chk({tag, " onehot"},  int'(bus.phase_onehot), 1 << v.ph);
    chk({tag, " running"}, int'(bus.running), int'(v.run));
    chk({tag, " halted"},  int'(bus.halted), int'(v.hlt));
    chk({tag, " done"},    int'(bus.instr_done), int'(v.done));
    chk({tag, " icount"},  int'(bus.instr_count), v.ic);
    chk({tag, " ccount"},  int'(bus.cycle_count), v.cc);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
    #1;
    chk({tag, " phase"},   int'(bus.phase), 0);
    chk({tag, " running"}, int'(bus.running), 0);
    chk({tag, " halted"},  int'(bus.halted), 0);
    chk({tag, " done"},    int'(bus.instr_done), 0);
    chk({tag, " icount"},  int'(bus.instr_count), 0);
    chk({tag, " ccount"},  int'(bus.cycle_count), 0);
  endtask

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_s[$];

  initial begin
    // exec mr halt step | phase run hlt done icnt ccnt
    // basic instruction, stalled instruction, pause at wrap, halt
    tab_a.push_back(mk(1,1,0,0, 0,0,0,0, 0, 0));
    tab_a.push_back(mk(1,1,0,0, 0,1,0,0, 0, 0));
    tab_a.push_back(mk(0,1,0,0, 1,1,0,0, 0, 1));
    tab_a.push_back(mk(0,1,0,0, 2,1,0,0, 0, 2));
    tab_a.push_back(mk(0,1,0,0, 3,1,0,0, 0, 3));
    tab_a.push_back(mk(0,1,0,0, 4,1,0,1, 0, 4));
    tab_a.push_back(mk(0,1,0,0, 0,1,0,0, 1, 5));
    tab_a.push_back(mk(0,1,0,0, 1,1,0,0, 1, 6));
    tab_a.push_back(mk(0,1,0,0, 2,1,0,0, 1, 7));
    tab_a.push_back(mk(0,0,0,0, 3,1,0,0, 1, 8));
    tab_a.push_back(mk(0,0,0,0, 3,1,0,0, 1, 9));
    tab_a.push_back(mk(0,0,0,0, 3,1,0,0, 1,10));
    tab_a.push_back(mk(0,1,0,0, 3,1,0,0, 1,11));
    tab_a.push_back(mk(0,1,0,0, 4,1,0,1, 1,12));
    tab_a.push_back(mk(0,1,0,0, 0,1,0,0, 2,13));
    tab_a.push_back(mk(1,1,0,0, 1,1,0,0, 2,14));
    tab_a.push_back(mk(1,1,0,0, 2,1,0,0, 2,15));
    tab_a.push_back(mk(0,1,0,0, 3,1,0,0, 2,16));
    tab_a.push_back(mk(0,1,0,0, 4,1,0,1, 2,17));
    tab_a.push_back(mk(0,1,0,0, 0,0,0,0, 3,18));
    tab_a.push_back(mk(0,1,0,0, 0,0,0,0, 3,18));
    tab_a.push_back(mk(1,1,0,0, 0,0,0,0, 3,18));
    tab_a.push_back(mk(0,1,0,0, 0,1,0,0, 3,18));
    tab_a.push_back(mk(0,1,1,0, 1,1,0,0, 3,19));
    tab_a.push_back(mk(0,1,0,0, 2,1,0,0, 3,20));
    tab_a.push_back(mk(0,1,0,0, 3,1,0,0, 3,21));
    tab_a.push_back(mk(0,1,1,0, 4,1,0,1, 3,22));
    tab_a.push_back(mk(1,1,0,0, 0,0,1,0, 4,23));
    tab_a.push_back(mk(0,1,0,1, 0,0,1,0, 4,23));
    tab_a.push_back(mk(1,1,0,0, 0,0,1,0, 4,23));

    // exec held through reset, pause cancel, exec rise with mem_ready, stall then reset
    tab_b.push_back(mk(1,1,0,0, 0,0,0,0, 0, 0));
    tab_b.push_back(mk(0,1,0,0, 0,0,0,0, 0, 0));
    tab_b.push_back(mk(1,1,0,0, 0,0,0,0, 0, 0));
    tab_b.push_back(mk(0,1,0,0, 0,1,0,0, 0, 0));
    tab_b.push_back(mk(1,1,0,0, 1,1,0,0, 0, 1));
    tab_b.push_back(mk(0,1,0,0, 2,1,0,0, 0, 2));
    tab_b.push_back(mk(1,1,0,0, 3,1,0,0, 0, 3));
    tab_b.push_back(mk(0,1,0,0, 4,1,0,1, 0, 4));
    tab_b.push_back(mk(0,1,0,0, 0,1,0,0, 1, 5));
    tab_b.push_back(mk(0,1,0,0, 1,1,0,0, 1, 6));
    tab_b.push_back(mk(0,1,0,0, 2,1,0,0, 1, 7));
    tab_b.push_back(mk(1,1,0,0, 3,1,0,0, 1, 8));
    tab_b.push_back(mk(0,1,0,0, 4,1,0,1, 1, 9));
    tab_b.push_back(mk(0,1,0,0, 0,0,0,0, 2,10));
    tab_b.push_back(mk(1,1,0,0, 0,0,0,0, 2,10));
    tab_b.push_back(mk(0,1,0,0, 0,1,0,0, 2,10));
    tab_b.push_back(mk(0,1,0,0, 1,1,0,0, 2,11));
    tab_b.push_back(mk(0,1,0,0, 2,1,0,0, 2,12));
    tab_b.push_back(mk(0,0,0,0, 3,1,0,0, 2,13));
    tab_b.push_back(mk(0,0,0,0, 3,1,0,0, 2,14));

`ifdef SINGLE_STEP_EN
    tab_s.push_back(mk(0,1,0,1, 0,0,0,0, 0, 0));
    tab_s.push_back(mk(0,1,0,0, 0,1,0,0, 0, 0));
    tab_s.push_back(mk(0,1,0,0, 1,1,0,0, 0, 1));
    tab_s.push_back(mk(0,1,0,0, 2,1,0,0, 0, 2));
    tab_s.push_back(mk(0,1,0,0, 3,1,0,0, 0, 3));
    tab_s.push_back(mk(0,1,0,0, 4,1,0,1, 0, 4));
    tab_s.push_back(mk(0,1,0,0, 0,0,0,0, 1, 5));
    tab_s.push_back(mk(0,1,0,0, 0,0,0,0, 1, 5));
`else
    tab_s.push_back(mk(0,1,0,1, 0,0,0,0, 0, 0));
    tab_s.push_back(mk(0,1,0,0, 0,0,0,0, 0, 0));
    tab_s.push_back(mk(0,1,0,1, 0,0,0,0, 0, 0));
    tab_s.push_back(mk(0,1,0,0, 0,0,0,0, 0, 0));
`endif

    bus.exec = 1'b0;  bus.step = 1'b0;  bus.halt_req = 1'b0;  bus.mem_ready = 1'b1;
    bus2.exec = 1'b0; bus2.step = 1'b0; bus2.halt_req = 1'b0; bus2.mem_ready = 1'b1;

    do_reset("reset0");
    foreach (tab_a[i]) apply(tab_a[i], $sformatf("A%0d", i));

    bus.exec = 1'b1;
    do_reset("reset_halt");
    foreach (tab_b[i]) apply(tab_b[i], $sformatf("B%0d", i));

    do_reset("reset_stall");
    foreach (tab_s[i]) apply(tab_s[i], $sformatf("S%0d", i));

    // 3-phase build: 16 instructions wrap the 4-bit counters back to 0
    @(negedge clock);
    bus2.exec = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("W%0d phase", k),  int'(bus2.phase), k % 3);
      chk($sformatf("W%0d onehot", k), int'(bus2.phase_onehot), 1 << (k % 3));
      chk($sformatf("W%0d done", k),   int'(bus2.instr_done), ((k % 3) == 2) ? 1 : 0);
      chk($sformatf("W%0d icount", k), int'(bus2.instr_count), (k / 3) % 16);
      chk($sformatf("W%0d ccount", k), int'(bus2.cycle_count), k % 16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
